// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage: access-size encodings,
// memory-stage FSM states and size classification helpers.
package mips_pkg;

    localparam logic [2:0] MSZ_W  = 3'b000;
    localparam logic [2:0] MSZ_H  = 3'b001;
    localparam logic [2:0] MSZ_HU = 3'b010;
    localparam logic [2:0] MSZ_B  = 3'b011;
    localparam logic [2:0] MSZ_BU = 3'b100;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_REQ  = 2'd1,
        MS_DONE = 2'd2
    } mstate_e;

    function automatic logic is_half(input logic [2:0] sz);
        return (sz == MSZ_H) || (sz == MSZ_HU);
    endfunction

    function automatic logic is_byte(input logic [2:0] sz);
        return (sz == MSZ_B) || (sz == MSZ_BU);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Handshaked data-memory bus between the memory stage (master) and the
// data memory (slave). rdata is valid in the same cycle as ack.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_extend.sv
// Load data lane selection and sign/zero extension. Purely combinational.
module load_extend
    import mips_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;

    // Pick the addressed half/byte, then extend according to the access size
    always_comb begin
        half_s = rdata[{lane[1], 4'b0000} +: 16];
        byte_s = rdata[{lane, 3'b000} +: 8];
        case (size)
            MSZ_H:   data = 32'(half_s);
            MSZ_HU:  data = {16'h0000, half_s};
            MSZ_B:   data = 32'(byte_s);
            MSZ_BU:  data = {24'h000000, byte_s};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage of the 5-stage MIPS pipeline: issues loads/stores on a
// handshaked data bus through an IDLE/REQ/DONE FSM, stalls the pipeline
// while an access is outstanding, and extends load data for writeback.
module mem_access_stage
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       MemReadM,
    input  logic                       MemWriteM,
    input  logic [2:0]                 MemSizeM,
    input  logic                       RegWriteM,
    input  logic [31:0]                ALUOutM,
    input  logic [31:0]                WriteDataM,
    output logic                       RegWriteOutM,
    output logic [31:0]                ReadDataM,
    output logic                       StallM,
    output logic                       AddrErrM,
    output logic                       BusErrM,
    mem_access_stage_if.master         dmem
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    mstate_e     state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bus_err_q, bus_err_d;

    logic        access;
    logic        aligned;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;
    logic [31:0] ext_data;

    assign access = MemReadM | MemWriteM;

    // Alignment check and little-endian byte-lane / store-data replication
    always_comb begin
        if (is_half(MemSizeM)) begin
            aligned    = ~ALUOutM[0];
            be_calc    = ALUOutM[1] ? 4'b1100 : 4'b0011;
            wdata_calc = {2{WriteDataM[15:0]}};
        end else if (is_byte(MemSizeM)) begin
            aligned    = 1'b1;
            be_calc    = 4'b0001 << ALUOutM[1:0];
            wdata_calc = {4{WriteDataM[7:0]}};
        end else begin
            aligned    = (ALUOutM[1:0] == 2'b00);
            be_calc    = 4'b1111;
            wdata_calc = WriteDataM;
        end
    end

    // EX/MEM inputs are frozen by StallM, so they still describe the access
    // when the ack arrives and can drive the extender directly.
    load_extend u_load_extend (
        .size  (MemSizeM),
        .lane  (ALUOutM[1:0]),
        .rdata (dmem.dmem_rdata),
        .data  (ext_data)
    );

    // Next-state, bus request fields, stall and error generation
    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        StallM    = 1'b0;
        AddrErrM  = 1'b0;
        case (state_q)
            MS_IDLE: begin
                bus_err_d = 1'b0;
                if (access) begin
                    if (aligned) begin
                        // Both strobes high is illegal; it degrades to a store
                        we_d    = MemWriteM;
                        addr_d  = {ALUOutM[31:2], 2'b00};
                        be_d    = be_calc;
                        wdata_d = wdata_calc;
                        req_d   = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = MS_REQ;
                        StallM  = 1'b1;
                    end else begin
                        AddrErrM = 1'b1;
                    end
                end
            end
            MS_REQ: begin
                StallM = 1'b1;
                if (dmem.dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = ext_data;
                    end
                    state_d = MS_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    rdata_d   = 32'h0;
                    state_d   = MS_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            MS_DONE: begin
                // Stall released so M/W captures; never re-issue from here
                state_d   = MS_IDLE;
                bus_err_d = 1'b0;
            end
            default: begin
                state_d = MS_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // State and registered bus/result flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MS_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            be_q      <= 4'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            cnt_q     <= 8'd0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign ReadDataM    = rdata_q;
    assign BusErrM      = bus_err_q;
    assign RegWriteOutM = RegWriteM & ~AddrErrM & ~((state_q == MS_DONE) & bus_err_q);

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a main instance with the default
// timeout and a second instance with TIMEOUT_CYCLES=4 sharing the pipeline
// inputs. Expected writeback results are queued when an access is driven
// and popped when the stage releases its stall.
module tb_mem_access_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  MemSizeM;
    logic        RegWriteM;
    logic [31:0] ALUOutM;
    logic [31:0] WriteDataM;

    logic        rwo, stall, aerr, berr;
    logic [31:0] rdm;
    logic        rwo_t, stall_t, aerr_t, berr_t;
    logic [31:0] rdm_t;
    logic        ack_to_en;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rd;
        logic        rwo;
        logic        berr;
    } exp_t;
    exp_t sb[$];

    mem_access_stage_if bus ();
    mem_access_stage_if bus_to ();

    assign bus_to.dmem_ack   = ack_to_en & bus.dmem_ack;
    assign bus_to.dmem_rdata = bus.dmem_rdata;

    mem_access_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .MemSizeM     (MemSizeM),
        .RegWriteM    (RegWriteM),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .RegWriteOutM (rwo),
        .ReadDataM    (rdm),
        .StallM       (stall),
        .AddrErrM     (aerr),
        .BusErrM      (berr),
        .dmem         (bus)
    );

    mem_access_stage #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk          (clk),
        .rst_n        (rst_n),
        .MemReadM     (MemReadM),
        .MemWriteM    (MemWriteM),
        .MemSizeM     (MemSizeM),
        .RegWriteM    (RegWriteM),
        .ALUOutM      (ALUOutM),
        .WriteDataM   (WriteDataM),
        .RegWriteOutM (rwo_t),
        .ReadDataM    (rdm_t),
        .StallM       (stall_t),
        .AddrErrM     (aerr_t),
        .BusErrM      (berr_t),
        .dmem         (bus_to)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n) begin
            assert (!(MemReadM && MemWriteM))
            else $error("FAIL illegal_rw: MemReadM=%0b MemWriteM=%0b both high", MemReadM, MemWriteM);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        MemSizeM   = MSZ_W;
        RegWriteM  = 1'b0;
        ALUOutM    = 32'h0;
        WriteDataM = 32'h0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] sz,
                         input logic rw, input logic [31:0] addr, input logic [31:0] wd);
        MemReadM   = rd;
        MemWriteM  = wr;
        MemSizeM   = sz;
        RegWriteM  = rw;
        ALUOutM    = addr;
        WriteDataM = wd;
    endtask

    // Runs one access on the main instance from an IDLE negedge; the bench
    // plays the memory, acking after 'waits' unacknowledged REQ cycles.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] sz, input logic rw,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] resp, input int waits,
                             input int exp_stalls, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input logic [31:0] exp_rd,
                             input logic exp_rwo);
        exp_t e;
        int   stalls;
        int   waited;
        bit   done;
        e.rd   = exp_rd;
        e.rwo  = exp_rwo;
        e.berr = 1'b0;
        sb.push_back(e);
        drive(rd, wr, sz, rw, addr, wd);
        stalls = 0;
        waited = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (stall) stalls++;
            if (bus.dmem_req) begin
                chk({tag, "_addr"},  bus.dmem_addr, {addr[31:2], 2'b00});
                chk({tag, "_we"},    32'(bus.dmem_we), 32'(wr));
                chk({tag, "_be"},    32'(bus.dmem_be), 32'(exp_be));
                chk({tag, "_wdata"}, bus.dmem_wdata, exp_wdata);
                if (waited == waits) begin
                    bus.dmem_ack   = 1'b1;
                    bus.dmem_rdata = resp;
                end else begin
                    waited++;
                    bus.dmem_ack = 1'b0;
                end
            end else begin
                bus.dmem_ack = 1'b0;
            end
            if (!stall) begin
                e = sb.pop_front();
                chk({tag, "_rdata"}, rdm, e.rd);
                chk({tag, "_regwr"}, 32'(rwo), 32'(e.rwo));
                chk({tag, "_buserr"}, 32'(berr), 32'(e.berr));
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk({tag, "_completion"}, 32'd0, 32'd1);
        chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
        idle_inputs();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int  n_req;
        bit  done;
        ack_to_en = 1'b1;
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        #1;
        // Reset state
        chk("rst_req",    32'(bus.dmem_req), 32'd0);
        chk("rst_we",     32'(bus.dmem_we), 32'd0);
        chk("rst_addr",   bus.dmem_addr, 32'h0);
        chk("rst_be",     32'(bus.dmem_be), 32'd0);
        chk("rst_wdata",  bus.dmem_wdata, 32'h0);
        chk("rst_rdata",  rdm, 32'h0);
        chk("rst_buserr", 32'(berr), 32'd0);
        chk("rst_stall",  32'(stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // LW with ack on the first REQ cycle (both instances complete)
        do_access("lw100", 1, 0, MSZ_W, 1, 32'h100, 32'h0, 32'hDEADBEEF, 0, 2,
                  4'b1111, 32'h0, 32'hDEADBEEF, 1'b1);
        chk("lw100_to_rdata", rdm_t, 32'hDEADBEEF);

        // Timeout on the TIMEOUT_CYCLES=4 instance, no ack anywhere
        ack_to_en = 1'b0;
        drive(1, 0, MSZ_W, 1, 32'h300, 32'h0);
        n_req = 0;
        done  = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (bus_to.dmem_req) n_req++;
            if (!stall_t) begin
                chk("to_buserr", 32'(berr_t), 32'd1);
                chk("to_rdata",  rdm_t, 32'h0);
                chk("to_regwr",  32'(rwo_t), 32'd0);
                chk("to_req",    32'(bus_to.dmem_req), 32'd0);
                chk("to_reqcyc", 32'(n_req), 32'd4);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) chk("to_completion", 32'd0, 32'd1);
        idle_inputs();
        @(negedge clk);
        #1;
        chk("to_idle_buserr", 32'(berr_t), 32'd0);
        chk("to_idle_stall",  32'(stall_t), 32'd0);
        chk("to_idle_state",  32'(dut_to.state_q), 32'(MS_IDLE));
        chk("to_idle_req",    32'(bus_to.dmem_req), 32'd0);
        ack_to_en = 1'b1;
        apply_reset();

        // Byte and half loads with sign/zero extension
        do_access("lb103", 1, 0, MSZ_B, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 2,
                  4'b1000, 32'h0, 32'hFFFFFF80, 1'b1);
        do_access("lbu103", 1, 0, MSZ_BU, 1, 32'h103, 32'h0, 32'h80FF0000, 0, 2,
                  4'b1000, 32'h0, 32'h00000080, 1'b1);
        do_access("lh102", 1, 0, MSZ_H, 1, 32'h102, 32'h0, 32'h80011234, 0, 2,
                  4'b1100, 32'h0, 32'hFFFF8001, 1'b1);
        do_access("lhu102", 1, 0, MSZ_HU, 1, 32'h102, 32'h0, 32'h80011234, 1, 3,
                  4'b1100, 32'h0, 32'h00008001, 1'b1);

        // Halfword store acked after 5 waiting cycles; ReadDataM unchanged
        do_access("sh202", 0, 1, MSZ_H, 0, 32'h202, 32'h1234ABCD, 32'h55555555, 5, 7,
                  4'b1100, 32'hABCDABCD, 32'h00008001, 1'b0);

        // Misaligned LW: error flagged, no request, no stall
        drive(1, 0, MSZ_W, 1, 32'h101, 32'h0);
        #1;
        chk("ae_flag",  32'(aerr), 32'd1);
        chk("ae_stall", 32'(stall), 32'd0);
        chk("ae_regwr", 32'(rwo), 32'd0);
        @(negedge clk);
        #1;
        chk("ae_req", 32'(bus.dmem_req), 32'd0);
        idle_inputs();
        @(negedge clk);

        // Reset asserted during the second REQ cycle
        drive(1, 0, MSZ_W, 1, 32'h400, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rmid_req_before", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_req",    32'(bus.dmem_req), 32'd0);
        chk("rmid_state",  32'(dut.state_q), 32'(MS_IDLE));
        chk("rmid_rdata",  rdm, 32'h0);
        chk("rmid_buserr", 32'(berr), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_access("lw500", 1, 0, MSZ_W, 1, 32'h500, 32'h0, 32'h0BADF00D, 1, 3,
                  4'b1111, 32'h0, 32'h0BADF00D, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
